// File: rtl/eth_avst_rx_mfb_adapter.sv
// eth_avst_rx_mfb_adapter: AVST RX (rx_avst_* in, no backpressure) to single-region MFB (tx_mfb_* out, meta {err_mtu,err_trunc,err_mac,len}) with byte swap, frame-safe FWFT FIFO, MTU policing and frame/err/drop counters (cnt_*)
module eth_avst_rx_mfb_adapter #(
  parameter int REGION_SIZE = 8,
  parameter int BLOCK_SIZE = 8,
  parameter int ITEM_WIDTH = 8,
  parameter int BYTE_SWAP = 1,
  parameter int ERR_WIDTH = 6,
  parameter int FIFO_DEPTH = 16,
  parameter int MTU = 16383,
  parameter int CNT_WIDTH = 32,
  localparam int N = REGION_SIZE * BLOCK_SIZE,
  localparam int DW = N * ITEM_WIDTH,
  localparam int PW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DW-1:0]        rx_avst_data,
  input  logic [PW-1:0]        rx_avst_empty,
  input  logic [ERR_WIDTH-1:0] rx_avst_error,
  input  logic                 rx_avst_sop,
  input  logic                 rx_avst_eop,
  input  logic                 rx_avst_valid,
  output logic [DW-1:0]        tx_mfb_data,
  output logic [18:0]          tx_mfb_meta,
  output logic                 tx_mfb_sof,
  output logic                 tx_mfb_eof,
  output logic [PW-1:0]        tx_mfb_eof_pos,
  output logic                 tx_mfb_src_rdy,
  input  logic                 tx_mfb_dst_rdy,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] cnt_frames,
  output logic [CNT_WIDTH-1:0] cnt_err,
  output logic [CNT_WIDTH-1:0] cnt_dropped
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = DW + 19 + 2 + PW;
  typedef enum logic [1:0] {IDLE, FRAME, DISCARD} state_t;
  state_t state, nxt;
  logic [DW-1:0] swapped, s_data;
  logic s_valid, s_sop, s_eop, s_mac;
  logic [PW-1:0] s_empty, w_pos;
  logic [16:0] len_q, add, len_base, len_sum, len_new;
  logic mac_q, mac_new, mtu_hit, bad, rd;
  logic wr, w_sof, w_eof, e_mtu, e_trunc, drop;
  logic [AW:0] wr_ptr, rd_ptr, free;
  logic [FW-1:0] mem [FIFO_DEPTH];
  for (genvar i = 0; i < N; i++) begin : g_swap
    assign swapped[i*ITEM_WIDTH +: ITEM_WIDTH] = BYTE_SWAP != 0 ? rx_avst_data[(N-1-i)*ITEM_WIDTH +: ITEM_WIDTH] : rx_avst_data[i*ITEM_WIDTH +: ITEM_WIDTH];
  end
  assign tx_mfb_src_rdy = wr_ptr != rd_ptr;
  assign rd = tx_mfb_src_rdy & tx_mfb_dst_rdy;
  assign free = (AW+1)'(FIFO_DEPTH) - (wr_ptr - rd_ptr);
  assign len_base = state == IDLE ? '0 : len_q;
  assign add = s_eop ? 17'(N) - 17'(s_empty) : 17'(N);
  assign len_sum = len_base + add;
  assign len_new = len_sum[16] ? 17'd65535 : len_sum;
  assign mtu_hit = len_new > 17'(MTU);
  assign mac_new = ((state != IDLE) & mac_q) | s_mac;
  assign bad = e_mtu | e_trunc | mac_new;
  assign w_pos = s_eop && !(state == FRAME && s_sop) ? PW'(N-1) - s_empty : PW'(N-1);
  always_comb begin
    wr = 1'b0;
    w_sof = 1'b0;
    w_eof = s_eop;
    e_mtu = 1'b0;
    e_trunc = 1'b0;
    drop = 1'b0;
    nxt = state;
    case (state)
      IDLE: if (s_valid && s_sop) begin
        wr = free >= (AW+1)'(2);
        w_sof = 1'b1;
        drop = !wr;
        nxt = s_eop ? IDLE : wr ? FRAME : DISCARD;
      end
      FRAME: if (s_valid) begin
        wr = 1'b1;
        if (s_sop) begin
          w_eof = 1'b1;
          e_trunc = 1'b1;
          drop = 1'b1;
          nxt = DISCARD;
        end else if (mtu_hit) begin
          w_eof = 1'b1;
          e_mtu = 1'b1;
          nxt = s_eop ? IDLE : DISCARD;
        end else if (free == (AW+1)'(1) && !s_eop) begin
          w_eof = 1'b1;
          e_trunc = 1'b1;
          nxt = DISCARD;
        end else nxt = s_eop ? IDLE : FRAME;
      end
      default: if (s_valid && s_eop) nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s_valid <= 1'b0;
      s_sop <= 1'b0;
      s_eop <= 1'b0;
      s_mac <= 1'b0;
      s_empty <= '0;
      s_data <= '0;
      state <= IDLE;
      len_q <= '0;
      mac_q <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_frames <= '0;
      cnt_err <= '0;
      cnt_dropped <= '0;
    end else begin
      s_valid <= rx_avst_valid;
      s_sop <= rx_avst_sop;
      s_eop <= rx_avst_eop;
      s_mac <= |rx_avst_error;
      s_empty <= rx_avst_empty;
      s_data <= swapped;
      state <= nxt;
      len_q <= wr ? len_new : len_q;
      mac_q <= wr ? mac_new : mac_q;
      wr_ptr <= wr_ptr + (AW+1)'(wr);
      rd_ptr <= rd_ptr + (AW+1)'(rd);
      cnt_frames <= cnt_clr ? '0 : cnt_frames + CNT_WIDTH'(wr && w_eof && !bad && !(&cnt_frames));
      cnt_err <= cnt_clr ? '0 : cnt_err + CNT_WIDTH'(wr && w_eof && bad && !(&cnt_err));
      cnt_dropped <= cnt_clr ? '0 : cnt_dropped + CNT_WIDTH'(drop && !(&cnt_dropped));
    end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr[AW-1:0]] <= {s_data, e_mtu, e_trunc, mac_new, len_new[15:0], w_sof, w_eof, w_pos};
  assign {tx_mfb_data, tx_mfb_meta, tx_mfb_sof, tx_mfb_eof, tx_mfb_eof_pos} = mem[rd_ptr[AW-1:0]];
endmodule

// File: tb/tb_eth_avst_rx_mfb_adapter.sv
// tb_eth_avst_rx_mfb_adapter: randomized frame-level checks of the AVST to MFB adapter against a byte-array reference model
module tb_eth_avst_rx_mfb_adapter;
  localparam int N = 64;
  typedef struct packed {
    logic [511:0] d;
    logic [18:0] m;
    logic sof;
    logic eof;
    logic [5:0] pos;
  } word_t;
  logic clk = 0, reset = 0;
  logic [511:0] rx_avst_data = '0;
  logic [5:0] rx_avst_empty = '0, rx_avst_error = '0;
  logic rx_avst_sop = 0, rx_avst_eop = 0, rx_avst_valid = 0;
  logic [511:0] tx_mfb_data;
  logic [18:0] tx_mfb_meta;
  logic tx_mfb_sof, tx_mfb_eof, tx_mfb_src_rdy;
  logic [5:0] tx_mfb_eof_pos;
  logic tx_mfb_dst_rdy = 1, cnt_clr = 0;
  logic [31:0] cnt_frames, cnt_err, cnt_dropped;
  logic [1:0] rdy_mode = 1;
  int tests = 0, fails = 0;
  int m_frames = 0, m_err = 0, m_drop = 0;
  logic [7:0] fb [0:4095];
  logic [5:0] fe [0:63];
  word_t exp_q[$], got_q[$];
  bit ok;

  always #5 clk = ~clk;

  eth_avst_rx_mfb_adapter #(.MTU(1518)) dut (
    .clk(clk), .reset(reset),
    .rx_avst_data(rx_avst_data), .rx_avst_empty(rx_avst_empty), .rx_avst_error(rx_avst_error),
    .rx_avst_sop(rx_avst_sop), .rx_avst_eop(rx_avst_eop), .rx_avst_valid(rx_avst_valid),
    .tx_mfb_data(tx_mfb_data), .tx_mfb_meta(tx_mfb_meta), .tx_mfb_sof(tx_mfb_sof), .tx_mfb_eof(tx_mfb_eof),
    .tx_mfb_eof_pos(tx_mfb_eof_pos), .tx_mfb_src_rdy(tx_mfb_src_rdy), .tx_mfb_dst_rdy(tx_mfb_dst_rdy),
    .cnt_clr(cnt_clr), .cnt_frames(cnt_frames), .cnt_err(cnt_err), .cnt_dropped(cnt_dropped)
  );

  always @(posedge clk) begin
    #1;
    tx_mfb_dst_rdy = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : rdy_mode[0];
  end

  always @(negedge clk)
    if (!reset && tx_mfb_src_rdy && tx_mfb_dst_rdy)
      got_q.push_back({tx_mfb_data, tx_mfb_eof ? tx_mfb_meta : 19'd0, tx_mfb_sof, tx_mfb_eof, tx_mfb_eof_pos});

  function automatic string fmt(input word_t w);
    return $sformatf("sof=%b eof=%b pos=%0d meta=%h data=%h", w.sof, w.eof, w.pos, w.m, w.d);
  endfunction

  task automatic set_rdy(input logic [1:0] m);
    rdy_mode = m;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic gen(input int err_pct);
    for (int i = 0; i < 4096; i++) fb[i] = 8'($urandom);
    for (int w = 0; w < 64; w++) fe[w] = $urandom_range(0, 99) < err_pct ? 6'(1 << $urandom_range(0, 5)) : 6'd0;
  endtask

  task automatic drive_words(input int nb, input int w0, input int w1, input int sop_at, input int gap);
    int nw = (nb + N - 1) / N;
    for (int w = w0; w < w1; w++) begin
      for (int i = 0; i < N; i++) rx_avst_data[(N-1-i)*8 +: 8] = fb[w*N+i];
      rx_avst_valid = 1;
      rx_avst_sop = w == sop_at;
      rx_avst_eop = w == nw - 1;
      rx_avst_empty = w == nw - 1 ? 6'(nw*N - nb) : 6'd0;
      rx_avst_error = fe[w];
      @(posedge clk);
      #2;
      rx_avst_valid = 0;
      repeat (gap) begin
        @(posedge clk);
        #2;
      end
    end
  endtask

  task automatic exp_frame(input int nb, input int nwr, input bit mtu, input bit trunc);
    int nw = (nb + N - 1) / N;
    bit eopw = nwr == nw;
    logic mac = 0;
    word_t e;
    for (int w = 0; w < nwr; w++) begin
      mac = mac | (|fe[w]);
      for (int j = 0; j < N; j++) e.d[j*8 +: 8] = fb[w*N+j];
      e.sof = w == 0;
      e.eof = w == nwr - 1;
      e.pos = e.eof && eopw ? 6'((nb - 1) % N) : 6'(N - 1);
      e.m = e.eof ? {mtu, trunc, mac, eopw ? 16'(nb) : 16'(nwr*N)} : 19'd0;
      if (e.eof && (mtu || trunc || mac)) m_err++;
      else if (e.eof) m_frames++;
      exp_q.push_back(e);
    end
  endtask

  task automatic await_out(input int n, output bit done);
    done = 0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(posedge clk);
      #2;
      done = got_q.size() >= n;
    end
    repeat (20) @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    #1 reset = 1;
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (tx_mfb_src_rdy !== 0 || cnt_frames !== 0 || cnt_err !== 0 || cnt_dropped !== 0) begin
      fails++;
      $display("FAIL reset: src_rdy=%b cnt=%0d/%0d/%0d, required 0 and 0/0/0", tx_mfb_src_rdy, cnt_frames, cnt_err, cnt_dropped);
    end
    reset = 0;
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (tx_mfb_src_rdy !== 0) begin
      fails++;
      $display("FAIL reset_release: src_rdy=%b, required 0", tx_mfb_src_rdy);
    end
  endtask

  task automatic test_single;
    for (int i = 0; i < 64; i++) begin
      fb[i] = i < 60 ? 8'(i) : 8'hFF;
      fe[i] = 0;
    end
    drive_words(60, 0, 1, 0, 0);
    tests++;
    if (tx_mfb_src_rdy !== 0) begin
      fails++;
      $display("FAIL single_early: src_rdy=%b one cycle after sampling, required 0", tx_mfb_src_rdy);
    end
    @(posedge clk);
    #2;
    tests++;
    if (tx_mfb_src_rdy !== 1 || tx_mfb_sof !== 1 || tx_mfb_eof !== 1 || tx_mfb_eof_pos !== 6'd59 || tx_mfb_data[7:0] !== 8'h00 || tx_mfb_meta !== 19'd60) begin
      fails++;
      $display("FAIL single_latency: src_rdy=%b sof=%b eof=%b pos=%0d byte0=%h meta=%h, required 1 1 1 59 00 00003c", tx_mfb_src_rdy, tx_mfb_sof, tx_mfb_eof, tx_mfb_eof_pos, tx_mfb_data[7:0], tx_mfb_meta);
    end
    exp_frame(60, 1, 0, 0);
    await_out(exp_q.size(), ok);
    tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL single_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL single_word %0d: got %s required %s", i, i < got_q.size() ? fmt(got_q[i]) : "none", fmt(exp_q[i]));
      end
    end
    exp_q.delete();
    got_q.delete();
    tests++;
    if (cnt_frames !== 32'(m_frames) || cnt_err !== 32'(m_err) || cnt_dropped !== 32'(m_drop)) begin
      fails++;
      $display("FAIL single_counters: got %0d/%0d/%0d required %0d/%0d/%0d", cnt_frames, cnt_err, cnt_dropped, m_frames, m_err, m_drop);
    end
  endtask

  task automatic test_stream;
    set_rdy(2);
    gen(0);
    drive_words(1500, 0, 24, 0, 2);
    exp_frame(1500, 24, 0, 0);
    for (int f = 0; f < 4; f++) begin
      int nb = $urandom_range(1, 1400);
      gen(20);
      drive_words(nb, 0, (nb + N - 1) / N, 0, 2);
      exp_frame(nb, (nb + N - 1) / N, 0, 0);
    end
    await_out(exp_q.size(), ok);
    tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL stream_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL stream_word %0d: got %s required %s", i, i < got_q.size() ? fmt(got_q[i]) : "none", fmt(exp_q[i]));
      end
    end
    exp_q.delete();
    got_q.delete();
    tests++;
    if (cnt_frames !== 32'(m_frames) || cnt_err !== 32'(m_err) || cnt_dropped !== 32'(m_drop)) begin
      fails++;
      $display("FAIL stream_counters: got %0d/%0d/%0d required %0d/%0d/%0d", cnt_frames, cnt_err, cnt_dropped, m_frames, m_err, m_drop);
    end
  endtask

  task automatic test_mtu;
    set_rdy(1);
    gen(0);
    drive_words(2000, 0, 32, 0, 0);
    exp_frame(2000, 24, 1, 0);
    await_out(exp_q.size(), ok);
    tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL mtu_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL mtu_word %0d: got %s required %s", i, i < got_q.size() ? fmt(got_q[i]) : "none", fmt(exp_q[i]));
      end
    end
    exp_q.delete();
    got_q.delete();
    tests++;
    if (cnt_frames !== 32'(m_frames) || cnt_err !== 32'(m_err) || cnt_dropped !== 32'(m_drop)) begin
      fails++;
      $display("FAIL mtu_counters: got %0d/%0d/%0d required %0d/%0d/%0d", cnt_frames, cnt_err, cnt_dropped, m_frames, m_err, m_drop);
    end
  endtask

  task automatic test_overflow;
    set_rdy(0);
    for (int f = 0; f < 20; f++) begin
      gen(0);
      drive_words(64, 0, 1, 0, 0);
      if (f < 15) exp_frame(64, 1, 0, 0);
      else m_drop++;
    end
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (cnt_dropped !== 32'(m_drop) || tx_mfb_src_rdy !== 1) begin
      fails++;
      $display("FAIL overflow_drop: dropped=%0d src_rdy=%b, required %0d and 1", cnt_dropped, tx_mfb_src_rdy, m_drop);
    end
    set_rdy(1);
    await_out(exp_q.size(), ok);
    tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL overflow_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL overflow_word %0d: got %s required %s", i, i < got_q.size() ? fmt(got_q[i]) : "none", fmt(exp_q[i]));
      end
    end
    exp_q.delete();
    got_q.delete();
    tests++;
    if (cnt_frames !== 32'(m_frames) || cnt_err !== 32'(m_err) || cnt_dropped !== 32'(m_drop)) begin
      fails++;
      $display("FAIL overflow_counters: got %0d/%0d/%0d required %0d/%0d/%0d", cnt_frames, cnt_err, cnt_dropped, m_frames, m_err, m_drop);
    end
  endtask

  task automatic test_trunc;
    set_rdy(0);
    gen(0);
    drive_words(1500, 0, 24, 0, 0);
    exp_frame(1500, 16, 0, 1);
    repeat (3) @(posedge clk);
    #2;
    set_rdy(1);
    await_out(exp_q.size(), ok);
    tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL trunc_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL trunc_word %0d: got %s required %s", i, i < got_q.size() ? fmt(got_q[i]) : "none", fmt(exp_q[i]));
      end
    end
    exp_q.delete();
    got_q.delete();
    tests++;
    if (cnt_frames !== 32'(m_frames) || cnt_err !== 32'(m_err) || cnt_dropped !== 32'(m_drop)) begin
      fails++;
      $display("FAIL trunc_counters: got %0d/%0d/%0d required %0d/%0d/%0d", cnt_frames, cnt_err, cnt_dropped, m_frames, m_err, m_drop);
    end
  endtask

  task automatic test_sop_in_frame;
    set_rdy(1);
    gen(0);
    drive_words(300, 0, 3, 0, 0);
    drive_words(300, 3, 5, 3, 0);
    exp_frame(300, 4, 0, 1);
    m_drop++;
    gen(0);
    drive_words(100, 0, 2, 0, 0);
    exp_frame(100, 2, 0, 0);
    await_out(exp_q.size(), ok);
    tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL sop_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL sop_word %0d: got %s required %s", i, i < got_q.size() ? fmt(got_q[i]) : "none", fmt(exp_q[i]));
      end
    end
    exp_q.delete();
    got_q.delete();
    tests++;
    if (cnt_frames !== 32'(m_frames) || cnt_err !== 32'(m_err) || cnt_dropped !== 32'(m_drop)) begin
      fails++;
      $display("FAIL sop_counters: got %0d/%0d/%0d required %0d/%0d/%0d", cnt_frames, cnt_err, cnt_dropped, m_frames, m_err, m_drop);
    end
  endtask

  task automatic test_reset_mid;
    set_rdy(0);
    gen(0);
    drive_words(300, 0, 3, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    tests++;
    if (tx_mfb_src_rdy !== 1) begin
      fails++;
      $display("FAIL reset_mid_fill: src_rdy=%b, required 1", tx_mfb_src_rdy);
    end
    #1 reset = 1;
    #1;
    tests++;
    if (tx_mfb_src_rdy !== 0 || cnt_frames !== 0 || cnt_err !== 0 || cnt_dropped !== 0) begin
      fails++;
      $display("FAIL reset_mid_async: src_rdy=%b cnt=%0d/%0d/%0d, required 0 and 0/0/0", tx_mfb_src_rdy, cnt_frames, cnt_err, cnt_dropped);
    end
    m_frames = 0;
    m_err = 0;
    m_drop = 0;
    @(posedge clk);
    #2 reset = 0;
    got_q.delete();
    drive_words(300, 3, 5, -1, 0);
    set_rdy(1);
    gen(0);
    drive_words(130, 0, 3, 0, 0);
    exp_frame(130, 3, 0, 0);
    await_out(exp_q.size(), ok);
    tests++;
    if (!ok || got_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL reset_mid_count: got %0d words, required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      tests++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL reset_mid_word %0d: got %s required %s", i, i < got_q.size() ? fmt(got_q[i]) : "none", fmt(exp_q[i]));
      end
    end
    exp_q.delete();
    got_q.delete();
    tests++;
    if (cnt_frames !== 32'(m_frames) || cnt_err !== 32'(m_err) || cnt_dropped !== 32'(m_drop)) begin
      fails++;
      $display("FAIL reset_mid_counters: got %0d/%0d/%0d required %0d/%0d/%0d", cnt_frames, cnt_err, cnt_dropped, m_frames, m_err, m_drop);
    end
  endtask

  task automatic test_cnt_clr;
    gen(0);
    drive_words(64, 0, 1, 0, 0);
    cnt_clr = 1;
    @(posedge clk);
    #2 cnt_clr = 0;
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (cnt_frames !== 0 || cnt_err !== 0 || cnt_dropped !== 0) begin
      fails++;
      $display("FAIL cnt_clr: cnt=%0d/%0d/%0d, required 0/0/0", cnt_frames, cnt_err, cnt_dropped);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_stream;
    test_mtu;
    test_overflow;
    test_trunc;
    test_sop_in_frame;
    test_reset_mid;
    test_cnt_clr;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
